// File: rtl/branch_ctrl.sv
// Branch resolution stage: tracks in-flight flag writers, stalls
// conditional branches until N/Z/V are current, then resolves them.
// Ports:
//   clk, rst                 clock, async active-high reset
//   br_valid/cond/target     branch in ID
//   fset_issue, flag_wr      flag writer issued / flag reg written
//   N_flag, Z_flag, V_flag   registered flags
//   stall                    hold IF/ID (combinational)
//   redirect, redirect_pc    one-cycle PC redirect (registered)
//   flush                    squash IF/ID (registered)
//   pend_cnt                 flag writers in flight (registered)
module branch_ctrl #(
  parameter int PC_W      = 16,
  parameter int PEND_W    = 2,
  parameter int FLUSH_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  input  logic [PC_W-1:0]   br_target,
  input  logic              fset_issue,
  input  logic              flag_wr,
  input  logic              N_flag,
  input  logic              Z_flag,
  input  logic              V_flag,
  output logic              stall,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              flush,
  output logic [PEND_W-1:0] pend_cnt
);

  localparam int FCW =
    (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FCW-1:0] FC_LOAD =
    FCW'(FLUSH_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FLUSH
  } state_t;

  state_t            state_q;
  logic [FCW-1:0]    fcnt_q;
  logic              redirect_q;
  logic              flush_q;
  logic [PC_W-1:0]   rpc_q;
  logic [PEND_W-1:0] pend_q;

  logic flags_ready;
  logic uncond;
  logic cond_true;
  logic busy;
  logic resolve;
  logic fset_eff;
  logic inc;
  logic dec;

  always_comb begin
    // Flag register loads on the edge, so its
    // output is stale during a flag_wr cycle.
    flags_ready = (pend_q == '0) & ~flag_wr;
    uncond      = (br_cond == 3'b111);
    case (br_cond)
      3'b000:  cond_true = ~Z_flag;
      3'b001:  cond_true = Z_flag;
      3'b010:  cond_true = ~Z_flag & ~N_flag;
      3'b011:  cond_true = N_flag;
      3'b100:  cond_true = Z_flag | (~Z_flag & ~N_flag);
      3'b101:  cond_true = N_flag | Z_flag;
      3'b110:  cond_true = V_flag;
      default: cond_true = 1'b1;
    endcase
    busy    = (state_q == S_FLUSH);
    resolve = br_valid & (flags_ready | uncond) & ~busy;
    stall   = ~rst & br_valid & ~busy
            & ~(flags_ready | uncond);
    // A squashed flag setter never writes flags.
    fset_eff = fset_issue & ~flush_q;
    inc = fset_eff & ~flag_wr & (pend_q != PEND_MAX);
    dec = flag_wr & ~fset_eff & (pend_q != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fcnt_q     <= '0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      rpc_q      <= '0;
      pend_q     <= '0;
    end else begin
      redirect_q <= 1'b0;
      if (inc) begin
        pend_q <= pend_q + 1'b1;
      end else if (dec) begin
        pend_q <= pend_q - 1'b1;
      end
      unique case (state_q)
        S_IDLE, S_WAIT: begin
          if (resolve && cond_true) begin
            state_q    <= S_FLUSH;
            redirect_q <= 1'b1;
            flush_q    <= 1'b1;
            rpc_q      <= br_target;
            fcnt_q     <= FC_LOAD;
          end else if (resolve || !br_valid) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_FLUSH: begin
          if (fcnt_q == '0) begin
            flush_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            fcnt_q <= fcnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = rpc_q;
  assign flush       = flush_q;
  assign pend_cnt    = pend_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: two instances (FLUSH_CYC 1 and 3)
// share stimulus and are checked against a behavioural model.
module tb_branch_ctrl;
  localparam int PC_W   = 16;
  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;
  localparam int VW     = PC_W + PEND_W + 3;

  logic clk = 1'b0;
  logic rst;
  logic br_valid;
  logic [2:0] br_cond;
  logic [PC_W-1:0] br_target;
  logic fset_issue, flag_wr;
  logic N_flag, Z_flag, V_flag;

  logic stall0, redir0, flush0;
  logic stall1, redir1, flush1;
  logic [PC_W-1:0] rpc0, rpc1;
  logic [PEND_W-1:0] pend0, pend1;

  int checks = 0;
  int failures = 0;

  // model state, index 0 -> FLUSH_CYC=1, 1 -> FLUSH_CYC=3
  int fc[2] = '{1, 3};
  int m_pend[2];
  int m_left[2];
  bit m_redir[2];
  logic [PC_W-1:0] m_rpc[2];

  always #5 clk = ~clk;

  branch_ctrl #(.PC_W(PC_W), .PEND_W(PEND_W), .FLUSH_CYC(1)) u0 (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_cond(br_cond),
    .br_target(br_target), .fset_issue(fset_issue), .flag_wr(flag_wr),
    .N_flag(N_flag), .Z_flag(Z_flag), .V_flag(V_flag),
    .stall(stall0), .redirect(redir0), .redirect_pc(rpc0),
    .flush(flush0), .pend_cnt(pend0));

  branch_ctrl #(.PC_W(PC_W), .PEND_W(PEND_W), .FLUSH_CYC(3)) u1 (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_cond(br_cond),
    .br_target(br_target), .fset_issue(fset_issue), .flag_wr(flag_wr),
    .N_flag(N_flag), .Z_flag(Z_flag), .V_flag(V_flag),
    .stall(stall1), .redirect(redir1), .redirect_pc(rpc1),
    .flush(flush1), .pend_cnt(pend1));

  function automatic bit truth(input logic [2:0] c,
                               input bit n, input bit z, input bit v);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit exp_stall(input int k);
    bit ready;
    if (rst || m_left[k] > 0 || !br_valid) return 1'b0;
    ready = (m_pend[k] == 0) && !flag_wr;
    return !(ready || br_cond == 3'd7);
  endfunction

  function automatic logic [VW-1:0] exp_vec(input int k);
    logic [PEND_W-1:0] p;
    p = PEND_W'(m_pend[k]);
    return {exp_stall(k), m_redir[k], m_left[k] > 0, p, m_rpc[k]};
  endfunction

  function automatic logic [VW-1:0] got_vec(input int k);
    if (k == 0) return {stall0, redir0, flush0, pend0, rpc0};
    return {stall1, redir1, flush1, pend1, rpc1};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0;
      m_left[k] = 0;
      m_redir[k] = 1'b0;
      m_rpc[k] = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit fl, ready, go, fs;
      fl = m_left[k] > 0;
      ready = (m_pend[k] == 0) && !flag_wr;
      go = br_valid && (ready || br_cond == 3'd7);
      fs = fset_issue && !fl;
      m_redir[k] = 1'b0;
      if (fl) begin
        m_left[k]--;
      end else if (go && truth(br_cond, N_flag, Z_flag, V_flag)) begin
        m_left[k] = fc[k];
        m_redir[k] = 1'b1;
        m_rpc[k] = br_target;
      end
      if (fs && !flag_wr) m_pend[k] = (m_pend[k] < PMAX) ? m_pend[k] + 1 : PMAX;
      else if (flag_wr && !fs && m_pend[k] > 0) m_pend[k]--;
    end
  endtask

  task automatic drive(input bit bv, input logic [2:0] c,
                       input logic [PC_W-1:0] t,
                       input bit fs, input bit fw);
    br_valid = bv;
    br_cond = c;
    br_target = t;
    fset_issue = fs;
    flag_wr = fw;
  endtask

  task automatic set_flags(input bit n, input bit z, input bit v);
    N_flag = n;
    Z_flag = z;
    V_flag = v;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 3'd0, 16'h0, 1'b0, 1'b0);
    set_flags(1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_vec(k) !== '0) begin
        failures++;
        $display("FAIL reset dut%0d got=%h exp=0", k, got_vec(k));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_taken_eq();
    set_flags(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      drive(c == 0, 3'd1, 16'h0040, 1'b0, 1'b0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL taken_eq c%0d dut%0d got=%h exp=%h",
                   c, k, got_vec(k), exp_vec(k));
        end
      end
      if (c == 1) begin
        checks++;
        if ({redir0, flush0, rpc0} !== {2'b11, 16'h0040}) begin
          failures++;
          $display("FAIL taken_eq_redirect got=%b%b %h exp=11 0040",
                   redir0, flush0, rpc0);
        end
      end
      tick();
    end
  endtask

  task automatic test_flag_wait();
    logic exp_st[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    set_flags(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c == 3) set_flags(1'b0, 1'b0, 1'b0);
      drive(c == 1 || c == 2 || c == 3, 3'd0, 16'h0080,
            c == 0, c == 2);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL flag_wait c%0d dut%0d got=%h exp=%h",
                   c, k, got_vec(k), exp_vec(k));
        end
      end
      checks++;
      if (stall0 !== exp_st[c]) begin
        failures++;
        $display("FAIL flag_wait_stall c%0d got=%b exp=%b",
                 c, stall0, exp_st[c]);
      end
      if (c == 4) begin
        checks++;
        if ({redir0, rpc0} !== {1'b1, 16'h0080}) begin
          failures++;
          $display("FAIL flag_wait_redirect got=%b %h exp=1 0080",
                   redir0, rpc0);
        end
      end
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic test_uncond_pending();
    for (int c = 0; c < 7; c++) begin
      drive(c == 1, 3'd7, 16'h1234, c == 0, c == 3);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL uncond c%0d dut%0d got=%h exp=%h",
                   c, k, got_vec(k), exp_vec(k));
        end
      end
      if (c == 1) begin
        checks++;
        if ({stall0, pend0} !== {1'b0, 2'd1}) begin
          failures++;
          $display("FAIL uncond_nostall got=%b %0d exp=0 1",
                   stall0, pend0);
        end
      end
      if (c == 2) begin
        checks++;
        if ({redir0, rpc0} !== {1'b1, 16'h1234}) begin
          failures++;
          $display("FAIL uncond_redirect got=%b %h exp=1 1234",
                   redir0, rpc0);
        end
      end
      tick();
    end
  endtask

  task automatic test_not_taken();
    set_flags(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 3'd2, 16'h0badd, 1'b0, 1'b0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL not_taken c%0d dut%0d got=%h exp=%h",
                   c, k, got_vec(k), exp_vec(k));
        end
      end
      checks++;
      if ({stall1, redir1, flush1} !== 3'b000) begin
        failures++;
        $display("FAIL not_taken_ctl got=%b%b%b exp=000",
                 stall1, redir1, flush1);
      end
      tick();
    end
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_pend_cnt();
    // issue, both, wr, wr@0, 4 issues, 3 drains
    bit fs_t[12] = '{1,1,0,0,1,1,1,1,0,0,0,0};
    bit fw_t[12] = '{0,1,1,1,0,0,0,0,1,1,1,0};
    int exp_p[12] = '{0,1,1,0,0,1,2,3,3,2,1,0};
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 3'd0, 16'h0, fs_t[c], fw_t[c]);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL pend c%0d dut%0d got=%h exp=%h",
                   c, k, got_vec(k), exp_vec(k));
        end
      end
      checks++;
      if (pend0 !== PEND_W'(exp_p[c])) begin
        failures++;
        $display("FAIL pend_cnt c%0d got=%0d exp=%0d",
                 c, pend0, exp_p[c]);
      end
      tick();
    end
  endtask

  task automatic test_flush3_and_reset();
    bit exp_fl[5] = '{0, 1, 1, 1, 0};
    set_flags(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive(c < 4, 3'd6, 16'h0c0d, 1'b0, 1'b0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL flush3 c%0d dut%0d got=%h exp=%h",
                   c, k, got_vec(k), exp_vec(k));
        end
      end
      checks++;
      if ({flush1, redir1} !== {exp_fl[c], c == 1}) begin
        failures++;
        $display("FAIL flush3_window c%0d got=%b%b exp=%b%b",
                 c, flush1, redir1, exp_fl[c], c == 1);
      end
      tick();
    end
    drive(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd0, 16'h0dd0, 1'b1, 1'b0);
    #1;
    checks++;
    if ({stall0, stall1} !== 2'b11) begin
      failures++;
      $display("FAIL wait_entry got=%b%b exp=11", stall0, stall1);
    end
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_vec(k) !== '0) begin
        failures++;
        $display("FAIL mid_wait_reset dut%0d got=%h exp=0",
                 k, got_vec(k));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 3'd7, PC_W'(16'h0100 + c), 1'b0, 1'b0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL b2b c%0d dut%0d got=%h exp=%h",
                   c, k, got_vec(k), exp_vec(k));
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit bv = 1'b0;
    logic [2:0] c = '0;
    logic [PC_W-1:0] t = '0;
    bit fw, fs;
    for (int n = 0; n < 600; n++) begin
      if (!(bv && (stall0 || stall1) && $urandom_range(9) != 0)) begin
        bv = $urandom_range(2) != 0;
        c = 3'($urandom);
        t = PC_W'($urandom);
      end
      fs = $urandom_range(2) == 0;
      fw = $urandom_range(2) == 0;
      drive(bv, c, t, fs, fw);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL random n%0d dut%0d got=%h exp=%h",
                   n, k, got_vec(k), exp_vec(k));
        end
      end
      tick();
      if (fw) set_flags(1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_taken_eq();
    test_flag_wait();
    test_uncond_pending();
    test_not_taken();
    test_pend_cnt();
    test_flush3_and_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
